// File: rtl/lpc_cycle_decoder.sv
// lpc_cycle_decoder: passive LPC snooper decoding I/O and memory read/write cycles into one record per completed cycle
module lpc_cycle_decoder #(
  parameter int SYNC_TIMEOUT = 1024,
  parameter bit ENABLE_MEM   = 1'b1,
  parameter bit ENABLE_WRITE = 1'b1
) (
  input  logic        lpc_clock,
  input  logic        reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic        out_valid,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_sync_timeout,
  output logic        out_sync_err,
  output logic        out_abort
);
  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CYCTYPE, ADDR, WDATA, TAR, SYNC, RDATA, TAREND} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic valid_n, tmo_n, err_n, abort_n;
  logic is_mem, is_write;
  assign is_mem   = out_cyctype_dir[2];
  assign is_write = out_cyctype_dir[1];
  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      wait_cnt         <= '0;
      out_valid        <= 1'b0;
      out_cyctype_dir  <= '0;
      out_addr         <= '0;
      out_data         <= '0;
      out_sync_timeout <= 1'b0;
      out_sync_err     <= 1'b0;
      out_abort        <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      wait_cnt         <= wait_cnt_n;
      out_valid        <= valid_n;
      out_sync_timeout <= tmo_n;
      out_sync_err     <= err_n;
      out_abort        <= abort_n;
      if (lpc_frame && state == CYCTYPE) out_cyctype_dir <= lpc_ad;
      if (lpc_frame && state == ADDR)
        out_addr <= is_mem ? {out_addr[27:0], lpc_ad} : {16'h0, out_addr[11:0], lpc_ad};
      if (lpc_frame && (state == WDATA || state == RDATA))
        out_data <= cnt[0] ? {lpc_ad, out_data[3:0]} : {out_data[7:4], lpc_ad};
    end
  end
  // cnt tracks address nibbles and the phase of two-clock states
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 3'd1;
    wait_cnt_n = wait_cnt;
    valid_n    = 1'b0;
    tmo_n      = 1'b0;
    err_n      = 1'b0;
    abort_n    = 1'b0;
    if (!lpc_frame) begin
      cnt_n   = '0;
      state_n = lpc_ad == 4'b0000 ? CYCTYPE : IDLE;
      abort_n = lpc_ad == 4'b1111 && state != IDLE;
    end else begin
      case (state)
        IDLE: cnt_n = '0;
        CYCTYPE: begin
          cnt_n   = '0;
          state_n = (lpc_ad[3] || (lpc_ad[2] && !ENABLE_MEM) || (lpc_ad[1] && !ENABLE_WRITE)) ? IDLE : ADDR;
        end
        ADDR: if (cnt == (is_mem ? 3'd7 : 3'd3)) begin
          cnt_n   = '0;
          state_n = is_write ? WDATA : TAR;
        end
        WDATA: if (cnt[0]) begin
          cnt_n   = '0;
          state_n = TAR;
        end
        TAR: if (cnt[0]) begin
          cnt_n      = '0;
          wait_cnt_n = '0;
          state_n    = SYNC;
        end
        SYNC: begin
          cnt_n = '0;
          if (lpc_ad == 4'b0000) state_n = is_write ? TAREND : RDATA;
          else if (lpc_ad == 4'b0101 || lpc_ad == 4'b0110) begin
            if (int'(wait_cnt) + 1 >= SYNC_TIMEOUT) begin
              tmo_n   = 1'b1;
              state_n = IDLE;
            end else wait_cnt_n = wait_cnt + CW'(1);
          end else begin
            err_n   = lpc_ad == 4'b1010;
            state_n = IDLE;
          end
        end
        RDATA: if (cnt[0]) begin
          cnt_n   = '0;
          state_n = TAREND;
        end
        TAREND: if (cnt[0]) begin
          cnt_n   = '0;
          valid_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb_lpc_cycle_decoder: directed LPC cycles against a default decoder and a short-timeout, memory-disabled one
module tb_lpc_cycle_decoder;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] ad;
  logic frame;
  logic v, tmo, err, ab, v4, tmo4, err4, ab4;
  logic [3:0] ct, ct4;
  logic [31:0] addr, addr4;
  logic [7:0] d, d4;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lpc_cycle_decoder dut (
    .lpc_clock(clk), .reset(rst), .lpc_ad(ad), .lpc_frame(frame),
    .out_valid(v), .out_cyctype_dir(ct), .out_addr(addr), .out_data(d),
    .out_sync_timeout(tmo), .out_sync_err(err), .out_abort(ab)
  );
  lpc_cycle_decoder #(.SYNC_TIMEOUT(4), .ENABLE_MEM(1'b0), .ENABLE_WRITE(1'b1)) dut4 (
    .lpc_clock(clk), .reset(rst), .lpc_ad(ad), .lpc_frame(frame),
    .out_valid(v4), .out_cyctype_dir(ct4), .out_addr(addr4), .out_data(d4),
    .out_sync_timeout(tmo4), .out_sync_err(err4), .out_abort(ab4)
  );
  task automatic cy(input logic f, input logic [3:0] a);
    frame = f;
    ad = a;
    @(posedge clk);
    #1;
  endtask
  task automatic nibs(input logic [31:0] a, input int n);
    for (int i = n - 1; i >= 0; i--) cy(1'b1, a[i*4 +: 4]);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    frame = 1'b1;
    ad = 4'hF;
    cy(1'b1, 4'hF);
    cy(1'b1, 4'hF);
    chk("reset_pulses", {28'h0, v, tmo, err, ab}, 32'h0);
    chk("reset_record", {ct, d, addr[19:0]}, 32'h0);
    rst = 1'b0;
    // T1: I/O read 0x0080, two wait syncs, data 0xA5
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h0080, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    cy(1'b1, 4'h5); cy(1'b1, 4'h5); cy(1'b1, 4'h0);
    cy(1'b1, 4'h5); cy(1'b1, 4'hA);
    cy(1'b1, 4'hF);
    chk("t1_tarend1_novalid", {31'h0, v}, 32'h0);
    cy(1'b1, 4'hF);
    chk("t1_valid", {31'h0, v}, 32'h1);
    chk("t1_cyctype", {28'h0, ct}, 32'h0);
    chk("t1_addr", addr, 32'h0000_0080);
    chk("t1_data", {24'h0, d}, 32'hA5);
    chk("t1_valid_small", {31'h0, v4}, 32'h1);
    cy(1'b1, 4'hF);
    chk("t1_valid_one_cycle", {31'h0, v}, 32'h0);
    // T2: memory write 0xFFFFFFF0 data 0x3C
    cy(1'b0, 4'h0); cy(1'b1, 4'h6); nibs(32'hFFFF_FFF0, 8);
    cy(1'b1, 4'hC); cy(1'b1, 4'h3);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    cy(1'b1, 4'h0);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t2_valid", {31'h0, v}, 32'h1);
    chk("t2_cyctype", {28'h0, ct}, 32'h6);
    chk("t2_addr", addr, 32'hFFFF_FFF0);
    chk("t2_data", {24'h0, d}, 32'h3C);
    chk("t2_nomem_novalid", {31'h0, v4}, 32'h0);
    // T3: I/O read with SYNC held at long wait; timeout after 4 waits on the small instance
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h0060, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    cy(1'b1, 4'h6); cy(1'b1, 4'h6); cy(1'b1, 4'h6);
    chk("t3_no_timeout_3", {31'h0, tmo4}, 32'h0);
    cy(1'b1, 4'h6);
    chk("t3_timeout_4", {31'h0, tmo4}, 32'h1);
    chk("t3_timeout_novalid", {31'h0, v4}, 32'h0);
    chk("t3_big_no_timeout", {31'h0, tmo}, 32'h0);
    cy(1'b1, 4'h6);
    chk("t3_timeout_one_cycle", {31'h0, tmo4}, 32'h0);
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h0061, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'h0);
    cy(1'b1, 4'hA); cy(1'b1, 4'h5);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t3_after_valid", {31'h0, v4}, 32'h1);
    chk("t3_after_record", {ct4, d4, addr4[19:0]}, {4'h0, 8'h5A, 20'h00061});
    chk("t3_big_after_valid", {31'h0, v}, 32'h1);
    // T4: host abort in address nibble 2, then immediate I/O write 0x002E data 0x11
    cy(1'b0, 4'h0); cy(1'b1, 4'h2); cy(1'b1, 4'h0);
    cy(1'b0, 4'hF);
    chk("t4_abort", {30'h0, ab, ab4}, 32'h3);
    cy(1'b0, 4'h0);
    chk("t4_abort_one_cycle", {31'h0, ab}, 32'h0);
    cy(1'b1, 4'h2); nibs(32'h002E, 4);
    cy(1'b1, 4'h1); cy(1'b1, 4'h1);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'h0);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t4_valid", {30'h0, v, v4}, 32'h3);
    chk("t4_addr", addr, 32'h0000_002E);
    chk("t4_record", {ct, d}, {20'h0, 4'h2, 8'h11});
    // T5: error sync on I/O read, then memory read ignored by the memory-disabled instance
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h0070, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'hA);
    chk("t5_sync_err", {30'h0, err, err4}, 32'h3);
    chk("t5_err_novalid", {30'h0, v, v4}, 32'h0);
    cy(1'b0, 4'h0); cy(1'b1, 4'h4); nibs(32'h1234_5678, 8);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'h0);
    cy(1'b1, 4'hC); cy(1'b1, 4'h9);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t5_mem_valid", {31'h0, v}, 32'h1);
    chk("t5_mem_addr", addr, 32'h1234_5678);
    chk("t5_mem_data", {24'h0, d}, 32'h9C);
    chk("t5_nomem_pulses", {28'h0, v4, tmo4, err4, ab4}, 32'h0);
    // T6: reset in the middle of RDATA
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h0090, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'h0);
    cy(1'b1, 4'h3);
    rst = 1'b1;
    cy(1'b1, 4'h4);
    rst = 1'b0;
    chk("t6_reset_pulses", {28'h0, v, tmo, err, ab}, 32'h0);
    chk("t6_reset_addr", addr, 32'h0);
    chk("t6_reset_record", {20'h0, ct, d}, 32'h0);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t6_no_stale_valid", {31'h0, v}, 32'h0);
    cy(1'b0, 4'h0); cy(1'b1, 4'h0); nibs(32'h03F8, 4);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF); cy(1'b1, 4'h0);
    cy(1'b1, 4'hE); cy(1'b1, 4'h7);
    cy(1'b1, 4'hF); cy(1'b1, 4'hF);
    chk("t6_valid", {31'h0, v}, 32'h1);
    chk("t6_addr", addr, 32'h0000_03F8);
    chk("t6_record", {ct, d}, {20'h0, 4'h0, 8'h7E});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
